// File: rtl/tank_level_ctrl_pkg.sv
// Purpose : shared types and helpers for the tank level controller.
// Latency : n/a (types, constants and a width helper only).
// Backpressure: n/a.
package tank_level_ctrl_pkg;

   // Controller states; the encoding is fixed so that downstream debug
   // tooling can decode the state register directly.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILLING = 2'd1,
      ST_FAULT   = 2'd2
   } state_t;

   // Reported fault cause, valid while the controller sits in ST_FAULT.
   typedef enum logic [1:0] {
      FC_NONE    = 2'b00,
      FC_INVALID = 2'b01,
      FC_TIMEOUT = 2'b10
   } fault_code_t;

   // Width needed to hold a level 0..n_sensors.
   function automatic int level_w(input int n_sensors);
      return $clog2(n_sensors + 1);
   endfunction

   // Level width for the default three-float tank.
   localparam int DEF_LEVEL_W = level_w(3);

endpackage

// File: rtl/tank_level_ctrl_debounce.sv
// Purpose : single-bit debouncer for one tank float switch.
// Latency : a raw change first sampled at edge k reaches o_stable at edge k+DEBOUNCE_CYCLES-1.
// Backpressure: none; samples every clock.
// Ports   : i_clk, i_rst_n (sync, active-low), i_raw (float switch), o_stable (debounced bit).
module level_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_stable
);

   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          w_hit;

   // The edge that would take the count to DEBOUNCE_CYCLES commits the new
   // value instead, so the counter never exceeds DEBOUNCE_CYCLES-1.
   assign w_hit = (r_cnt >= CW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (i_raw == r_stable) begin
         r_cnt <= '0;
      end else if (w_hit) begin
         r_stable <= i_raw;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/tank_level_ctrl.sv
// Purpose : debounce tank floats, decode level, run fill valve FSM and irrigation gate.
// Latency : raw change at edge k -> level_code at k+DEBOUNCE_CYCLES -> fill_valve at k+DEBOUNCE_CYCLES+1.
// Backpressure: none; irrigation requests are simply granted or withheld each cycle.
// Ports   : i_clk, i_rst_n (sync, active-low), i_level_raw, i_irr_req, i_fault_clr;
//           o_level_code, o_level_valid, o_fill_valve, o_irr_grant, o_fault, o_fault_code.
module tank_level_ctrl
   import tank_level_ctrl_pkg::*;
#(
   parameter int N_SENSORS       = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FILL_ON_LEVEL   = 0,
   parameter int IRR_MIN_LEVEL   = 1,
   parameter int FILL_TIMEOUT    = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [N_SENSORS-1:0]          i_level_raw,
   input  logic                          i_irr_req,
   input  logic                          i_fault_clr,
   output logic [level_w(N_SENSORS)-1:0] o_level_code,
   output logic                          o_level_valid,
   output logic                          o_fill_valve,
   output logic                          o_irr_grant,
   output logic                          o_fault,
   output logic [1:0]                    o_fault_code
);

   localparam int LW = level_w(N_SENSORS);
   localparam int TW = $clog2(FILL_TIMEOUT + 1);

   // ---------------------------------------------------------------
   // Per-float debouncers
   // ---------------------------------------------------------------
   logic [N_SENSORS-1:0] w_stable;

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_deb
      level_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_raw    (i_level_raw[g]),
         .o_stable (w_stable[g])
      );
   end

   // ---------------------------------------------------------------
   // Thermometer decode
   // ---------------------------------------------------------------
   // A float reading wet above a dry one is physically impossible; shifting
   // in a 1 at the bottom lets bit 0 be compared against "ground".
   logic [N_SENSORS:0]   w_ext;
   logic [N_SENSORS-1:0] w_bad;
   logic                 w_valid;
   logic [LW-1:0]        w_pop;

   assign w_ext   = {w_stable, 1'b1};
   assign w_bad   = w_stable & ~w_ext[N_SENSORS-1:0];
   assign w_valid = (w_bad == '0);

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N_SENSORS; i++) begin
         w_pop = w_pop + LW'(w_stable[i]);
      end
   end

   logic [LW-1:0] r_level_code;
   logic [LW-1:0] r_code_d;      // level_code one edge earlier, for rise detection
   logic          r_level_valid;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_level_code  <= '0;
         r_code_d      <= '0;
         r_level_valid <= 1'b1;
      end else begin
         r_level_valid <= w_valid;
         r_code_d      <= r_level_code;
         // An illegal pattern keeps the last trusted level on the output.
         if (w_valid) begin
            r_level_code <= w_pop;
         end
      end
   end

   // ---------------------------------------------------------------
   // Fill controller FSM
   // ---------------------------------------------------------------
   state_t      r_state,      w_state_nxt;
   fault_code_t r_fault_code, w_fc_nxt;
   logic [TW-1:0] r_tmo_cnt,  w_tmo_nxt;
   logic          w_level_rise;
   logic          r_irr_grant;

   assign w_level_rise = (r_level_code > r_code_d);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_fault_code <= FC_NONE;
         r_tmo_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_fault_code <= w_fc_nxt;
         r_tmo_cnt    <= w_tmo_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fc_nxt    = r_fault_code;
      w_tmo_nxt   = r_tmo_cnt;

      if (!r_level_valid) begin
         // Sensor inconsistency wins over everything, including a timeout
         // expiring on the same edge.
         w_state_nxt = ST_FAULT;
         w_fc_nxt    = FC_INVALID;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_level_code <= LW'(FILL_ON_LEVEL)) begin
                  w_state_nxt = ST_FILLING;
                  w_tmo_nxt   = '0;
               end
            end
            ST_FILLING: begin
               if (r_level_code == LW'(N_SENSORS)) begin
                  w_state_nxt = ST_IDLE;
                  w_tmo_nxt   = '0;
               end else if (w_level_rise) begin
                  w_tmo_nxt = '0;
               end else if (r_tmo_cnt >= TW'(FILL_TIMEOUT - 1)) begin
                  // This edge is the FILL_TIMEOUT-th without progress.
                  w_state_nxt = ST_FAULT;
                  w_fc_nxt    = FC_TIMEOUT;
               end else begin
                  w_tmo_nxt = r_tmo_cnt + 1'b1;
               end
            end
            ST_FAULT: begin
               if (i_fault_clr) begin
                  w_state_nxt = ST_IDLE;
                  w_fc_nxt    = FC_NONE;
                  w_tmo_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_fc_nxt    = FC_NONE;
               w_tmo_nxt   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Irrigation gate
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_irr_grant <= 1'b0;
      end else begin
         r_irr_grant <= i_irr_req && (r_state != ST_FAULT) && r_level_valid &&
                        (r_level_code >= LW'(IRR_MIN_LEVEL));
      end
   end

   assign o_level_code  = r_level_code;
   assign o_level_valid = r_level_valid;
   assign o_fill_valve  = (r_state == ST_FILLING);
   assign o_fault       = (r_state == ST_FAULT);
   assign o_fault_code  = r_fault_code;
   assign o_irr_grant   = r_irr_grant;

endmodule

// File: doc/tank_level_ctrl.md
Name: tank_level_ctrl

Overview:
Parametrised, sequential successor to the combinational water-level decoder. Debounces N thermometer-coded tank level sensors and detects impossible sensor combinations. Runs a fill-valve controller with hysteresis and a fill timeout, and grants irrigation requests only when the water level is adequate. Sits between the raw tank float switches and the pump/valve drivers of the residential irrigation controller.

Parameters:
N_SENSORS, 3, number of level sensors; bit 0 is the lowest float.
DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a sensor change (>=1).
FILL_ON_LEVEL, 0, level at or below which filling starts.
IRR_MIN_LEVEL, 1, minimum level for an irrigation grant.
FILL_TIMEOUT, 16, maximum cycles in FILLING without a level increase.

Ports:
clk  in  1  system clock; all state on the rising edge.
rst_n  in  1  synchronous reset, active-low.
level_raw  in  N_SENSORS  raw float switches; 1 = water present at that height.
irr_req  in  1  irrigation request from the scheduler.
fault_clr  in  1  operator fault acknowledge (level-sensitive).
level_code  out  $clog2(N_SENSORS+1)  debounced level, 0..N_SENSORS.
level_valid  out  1  debounced pattern is a legal thermometer code.
fill_valve  out  1  inlet valve open.
irr_grant  out  1  irrigation permitted.
fault  out  1  controller is in FAULT.
fault_code  out  2  00 none, 01 invalid sensor combination, 10 fill timeout.

Behaviour:
- Reset: applies when rst_n=0 at a clk edge. Effect: stable sensors=0, debounce counters=0, level_code=0, level_valid=1, state=IDLE, timeout counter=0, fill_valve=0, irr_grant=0, fault=0, fault_code=00. Reset mid-fill closes the valve at that same edge.
- Debounce (per bit): the counter increments each edge where raw differs from stable, and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES, the stable bit takes the raw value and the counter clears. A raw change first sampled at edge k updates stable at edge k+DEBOUNCE_CYCLES-1.
- Decode (registered, +1 edge):
  - level_valid=1 iff stable is 0...01...1, i.e. no bit i set with bit i-1 clear.
  - level_code = popcount(stable) when valid; holds its previous value when invalid.
- FSM (Moore, +1 edge after decode). States: IDLE, FILLING, FAULT.
  - Any state, level_valid=0 -> FAULT, fault_code=01. Highest priority; overrides a timeout in the same cycle.
  - IDLE -> FILLING when level_code <= FILL_ON_LEVEL.
  - FILLING -> IDLE when level_code == N_SENSORS.
  - FILLING timeout counter: clears on entry and on any level_code increase. When it reaches FILL_TIMEOUT -> FAULT, fault_code=10.
  - FAULT -> IDLE only when fault_clr=1 and level_valid=1. fault_clr is ignored while the code is invalid. fault_code returns to 00 on exit.
- Outputs:
  - fill_valve = (state==FILLING).
  - fault = (state==FAULT).
  - irr_grant is registered: irr_req & state!=FAULT & level_valid & level_code>=IRR_MIN_LEVEL.
  - Filling and irrigating at the same time is allowed.
- End-to-end latency: a raw change becomes visible on fill_valve at edge k+DEBOUNCE_CYCLES+1.
- Width rules: counters are sized with $clog2(max+1) and saturate; no wrap-around.

Decomposition:
- Shared package: FSM state encodings (IDLE=2'd0, FILLING=2'd1, FAULT=2'd2); fault codes FC_NONE, FC_INVALID, FC_TIMEOUT; a level-width helper constant.
- Sub-module: level_debounce (one bit, parameter DEBOUNCE_CYCLES), instantiated N_SENSORS times via generate.
- FSM, decode and timeout logic stay in tank_level_ctrl.

Test Plan:
All scenarios use the defaults: N=3, DEBOUNCE_CYCLES=4, FILL_TIMEOUT=16, FILL_ON_LEVEL=0, IRR_MIN_LEVEL=1.
1. Reset, then raw=000 -> all outputs 0, level_valid=1. fill_valve=1 after the first post-reset edge. FAULT with fault_code=10 exactly 16 edges after entering FILLING.
2. In FILLING, raw steps 001, 011, 111, each held 10 cycles -> level_code 1, 2, 3, each appearing 4 edges after the step. Timeout never fires. fill_valve drops 5 edges after 111.
3. Stable 111, bit 2 glitches to 0 for 3 cycles -> level_code stays 3, no state change. Same glitch held for 4 cycles -> level_code=2.
4. raw=101 held 4 cycles -> level_valid=0, fault=1, fault_code=01, fill_valve=0, irr_grant=0. fault_clr=1 while still 101 -> stays in FAULT. raw=111 debounced, then fault_clr=1 -> IDLE, fault_code=00.
5. Level 0 with irr_req=1 -> irr_grant=0. Level 1 -> irr_grant=1 one edge after level_code=1. Enter FAULT -> irr_grant=0 on the next edge.
6. rst_n=0 for one edge during FILLING with level 2 -> fill_valve=0 and level_code=0 at that edge. After release, level_code=2 following re-debounce.
